sa_fifo_ctrl: RTL and testbench
===============================

# sa_fifo_ctrl

Parametrised synchronous FIFO for the systolic array's operand and result streams. It has configurable data width and depth, full, empty and almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow errors and a synchronous flush. Storage is an internal 1-read/1-write register array with a registered read path. It sits between the host-side loader and the array edge cells, one instance per row/column channel.

## Interface
Parameters:
- DW, 16, data width in bits.
- AW, 2, address width; depth = 2**AW entries (AW ≥ 1).
- AFULL_TH, 3, afull asserts when count ≥ AFULL_TH (1 ≤ AFULL_TH ≤ 2**AW).
- AEMPTY_TH, 1, aempty asserts when count ≤ AEMPTY_TH (0 ≤ AEMPTY_TH < 2**AW).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; empties the FIFO and clears the error flags.
- wr_en  in  1  push request.
- wr_data  in  DW  push data.
- rd_en  in  1  pop request.
- rd_data  out  DW  popped data, registered.
- rd_valid  out  1  one-cycle pulse: rd_data holds a newly popped word.
- full  out  1  count == 2**AW.
- afull  out  1  count ≥ AFULL_TH.
- empty  out  1  count == 0.
- aempty  out  1  count ≤ AEMPTY_TH.
- count  out  AW+1  occupancy, 0..2**AW.
- ovf  out  1  sticky; set by a rejected push.
- udf  out  1  sticky; set by a rejected pop.

## Operation
- Pointers:
  - wr_ptr and rd_ptr are each AW+1 bits wide; the MSB is the wrap bit.
  - RAM index is ptr[AW-1:0].
  - count = wr_ptr − rd_ptr, modulo 2**(AW+1).
  - full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
- Push accepted = wr_en & ~full & ~clr. On accept: write wr_data to ram[wr_ptr index], then wr_ptr += 1.
- Pop accepted = rd_en & ~empty & ~clr. On accept: load rd_data from ram[rd_ptr index], rd_ptr += 1, set rd_valid for the next cycle.
- All flags and the acceptance decisions use pre-edge state:
  - Push while full is rejected even if a pop is accepted in the same cycle.
  - Pop while empty is rejected even if a push is accepted in the same cycle. There is no fall-through.
- Simultaneous accepted push and pop: count is unchanged and both pointers advance. They cannot address the same entry, because that would require the FIFO to be full, and a push while full is rejected.
- Rejected push (wr_en & full & ~clr): ovf ← 1; no state change. Rejected pop (rd_en & empty & ~clr): udf ← 1; no state change.
- ovf and udf stay set until clr or rst_n.
- clr:
  - wr_ptr, rd_ptr, ovf, udf and rd_valid go to 0.
  - Any wr_en/rd_en in the same cycle is ignored and does not set the error flags.
  - RAM contents and rd_data are not altered.
- Pointer wrap: an index wraps from 2**AW−1 to 0 and toggles the wrap bit; no special case beyond this.
- RAM has no reset; its contents are undefined until written.

## Timing
- Reset values (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, rd_data = 0, rd_valid = 0, ovf = udf = 0.
  - Therefore count = 0, empty = 1, full = 0, afull = 0 (AFULL_TH ≥ 1), aempty = 1.
- Reset asserted mid-operation discards all stored words immediately. It is not gated by clk.
- Flags and count are combinational from the pointer registers. They update in the cycle after the edge that accepted a push or pop.
- Push latency: word accepted at edge N is poppable (empty = 0) from cycle N+1. A pop at edge N+1 returns it at N+2.
- Pop latency: 1 cycle. rd_en accepted at edge N gives rd_data valid and rd_valid = 1 during cycle N+1.
- rd_valid is high for one cycle per accepted pop. Back-to-back pops give consecutive rd_valid cycles.
- rd_data holds its last value when no pop is accepted.
- Sustained throughput: one push plus one pop per cycle.

## Test plan
- Reset, then push 0x1111, 0x2222, 0x3333, 0x4444 (DW = 16, AW = 2) -> count steps 1..4; afull at count 3; full at count 4; ovf = 0.
- While full, push 0x5555 with rd_en = 1 -> pop accepted (rd_data = 0x1111 next cycle), push rejected, ovf = 1, count = 3.
- From empty, pop with a simultaneous push of 0xAAAA -> udf = 1, rd_valid stays 0, count = 1. The next pop returns 0xAAAA.
- Continuous push+pop for 10 cycles with an incrementing pattern starting at 0x0000 -> data returns in order across two pointer wraps; count stays constant; rd_valid high every cycle.
- With count = 2, ovf = 1, assert clr together with wr_en and rd_en -> count = 0, empty = 1, ovf = udf = 0, rd_valid = 0, rd_data unchanged.
- With count = 3, drop rst_n low between clock edges -> empty = 1 and count = 0 immediately (before the next edge), rd_data = 0. After release, a push/pop of 0x1234 works normally.

Source files
------------

// File: rtl/sa_fifo_ctrl.sv
// sa_fifo_ctrl: parametrised synchronous FIFO for the systolic array operand and
// result channels, with a registered read path.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous flush (pointers, rd_valid and error flags)
//   wr_en    in   push request
//   wr_data  in   push data [DW]
//   rd_en    in   pop request
//   rd_data  out  popped data, registered [DW]
//   rd_valid out  one-cycle pulse for each accepted pop
//   full     out  count == 2**AW
//   afull    out  count >= AFULL_TH
//   empty    out  count == 0
//   aempty   out  count <= AEMPTY_TH
//   count    out  occupancy 0..2**AW [AW+1]
//   ovf      out  sticky, set by a rejected push
//   udf      out  sticky, set by a rejected pop
module sa_fifo_ctrl #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 2,
  parameter int unsigned AFULL_TH  = 3,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          afull,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          push_acc;
  logic          pop_acc;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Status derived from the pointers; the MSB is the wrap bit.
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign afull  = (count >= PW'(AFULL_TH));
  assign aempty = (count <= PW'(AEMPTY_TH));

  // Acceptance uses pre-edge flags only, so there is no fall-through.
  assign push_acc = wr_en & ~full & ~clr;
  assign pop_acc  = rd_en & ~empty & ~clr;

  // Next-state logic for pointers, read path and sticky errors.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (clr) begin
      // Flush leaves RAM and rd_data untouched.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        rd_data_d  = mem_q[rd_idx];
        rd_valid_d = 1'b1;
      end
      if (wr_en && full) begin
        ovf_d = 1'b1;
      end
      if (rd_en && empty) begin
        udf_d = 1'b1;
      end
    end
  end

  // Control and read-path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_sa_fifo_ctrl.sv
// Directed bench for sa_fifo_ctrl with DW=16, AW=2, AFULL_TH=3, AEMPTY_TH=1.
module tb_sa_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        afull;
  logic        empty;
  logic        aempty;
  logic [2:0]  count;
  logic        ovf;
  logic        udf;

  int n_vec;
  int n_err;

  sa_fifo_ctrl #(
    .DW(16), .AW(2), .AFULL_TH(3), .AEMPTY_TH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .afull(afull), .empty(empty), .aempty(aempty),
    .count(count), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given request; inputs return to idle 1 ns after the edge.
  task automatic cyc(input logic c, input logic w, input logic [15:0] d, input logic r);
    clr     = c;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] c, input logic f,
                             input logic af, input logic e, input logic ae);
    check({tag, ".count"},  32'(count),  32'(c));
    check({tag, ".full"},   32'(full),   32'(f));
    check({tag, ".afull"},  32'(afull),  32'(af));
    check({tag, ".empty"},  32'(empty),  32'(e));
    check({tag, ".aempty"}, 32'(aempty), 32'(ae));
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_flags("rst", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst.rd_data",  32'(rd_data),  32'h0);
    check("rst.rd_valid", 32'(rd_valid), 32'h0);
    check("rst.ovf",      32'(ovf),      32'h0);
    check("rst.udf",      32'(udf),      32'h0);
    rst_n = 1'b1;

    // Fill to full.
    cyc(1'b0, 1'b1, 16'h1111, 1'b0);
    check_flags("push1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'h2222, 1'b0);
    check_flags("push2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h3333, 1'b0);
    check_flags("push3", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h4444, 1'b0);
    check_flags("push4", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    check("push4.ovf", 32'(ovf), 32'h0);

    // Push while full with a pop: pop accepted, push rejected.
    cyc(1'b0, 1'b1, 16'h5555, 1'b1);
    check("fullpp.rd_data",  32'(rd_data),  32'h1111);
    check("fullpp.rd_valid", 32'(rd_valid), 32'h1);
    check("fullpp.ovf",      32'(ovf),      32'h1);
    check_flags("fullpp", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

    // Drain; 0x5555 must not appear.
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("drain1.rd_data", 32'(rd_data), 32'h2222);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("drain2.rd_data", 32'(rd_data), 32'h3333);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("drain3.rd_data",  32'(rd_data),  32'h4444);
    check("drain3.rd_valid", 32'(rd_valid), 32'h1);
    check_flags("drain3", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    check("idle.rd_valid", 32'(rd_valid), 32'h0);
    check("idle.rd_data",  32'(rd_data),  32'h4444);

    // Pop from empty with a simultaneous push: pop rejected, no fall-through.
    cyc(1'b0, 1'b1, 16'hAAAA, 1'b1);
    check("emptypp.udf",      32'(udf),      32'h1);
    check("emptypp.rd_valid", 32'(rd_valid), 32'h0);
    check("emptypp.rd_data",  32'(rd_data),  32'h4444);
    check("emptypp.count",    32'(count),    32'h1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("popA.rd_data",  32'(rd_data),  32'hAAAA);
    check("popA.rd_valid", 32'(rd_valid), 32'h1);
    check("popA.count",    32'(count),    32'h0);
    check("popA.udf",      32'(udf),      32'h1);

    // Flush clears sticky errors.
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    check("clr0.ovf", 32'(ovf), 32'h0);
    check("clr0.udf", 32'(udf), 32'h0);

    // Streaming push+pop across two pointer wraps.
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 16'(i + 1), 1'b1);
      check($sformatf("stream%0d.rd_data", i),  32'(rd_data),  32'(i));
      check($sformatf("stream%0d.rd_valid", i), 32'(rd_valid), 32'h1);
      check($sformatf("stream%0d.count", i),    32'(count),    32'h1);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("streamlast.rd_data", 32'(rd_data), 32'h000A);
    check_flags("streamlast", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Build count=2 with ovf=1, then flush with both requests.
    cyc(1'b0, 1'b1, 16'hD001, 1'b0);
    cyc(1'b0, 1'b1, 16'hD002, 1'b0);
    cyc(1'b0, 1'b1, 16'hD003, 1'b0);
    cyc(1'b0, 1'b1, 16'hD004, 1'b0);
    cyc(1'b0, 1'b1, 16'hD005, 1'b0);
    check("ovf2.ovf",   32'(ovf),   32'h1);
    check("ovf2.count", 32'(count), 32'h4);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("d1.rd_data", 32'(rd_data), 32'hD001);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("d2.rd_data", 32'(rd_data), 32'hD002);
    check("d2.count",   32'(count),   32'h2);
    cyc(1'b1, 1'b1, 16'hEEEE, 1'b1);
    check_flags("clr", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr.ovf",      32'(ovf),      32'h0);
    check("clr.udf",      32'(udf),      32'h0);
    check("clr.rd_valid", 32'(rd_valid), 32'h0);
    check("clr.rd_data",  32'(rd_data),  32'hD002);
    cyc(1'b0, 1'b1, 16'hE0E0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("postclr.rd_data", 32'(rd_data), 32'hE0E0);

    // Asynchronous reset between edges with data stored.
    cyc(1'b0, 1'b1, 16'h7001, 1'b0);
    cyc(1'b0, 1'b1, 16'h7002, 1'b0);
    cyc(1'b0, 1'b1, 16'h7003, 1'b0);
    check("prerst.count", 32'(count), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check_flags("arst", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("arst.rd_data", 32'(rd_data), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b1, 16'h1234, 1'b0);
    check("post.count", 32'(count), 32'h1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    check("post.rd_data",  32'(rd_data),  32'h1234);
    check("post.rd_valid", 32'(rd_valid), 32'h1);
    check("post.empty",    32'(empty),    32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
